// File: rtl/shared_resource_arbiter_if.sv
// Bundle between the two pipelines, the shared resource and the arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface shared_resource_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req_1;
    logic [DATA_W-1:0] data_1;
    logic              flush_1;
    logic              req_2;
    logic [DATA_W-1:0] data_2;
    logic              flush_2;
    logic              res_start;
    logic [DATA_W-1:0] res_operand;
    logic              res_id;
    logic              res_done;
    logic [DATA_W-1:0] res_result;
    logic              out_valid_1;
    logic [DATA_W-1:0] out_data_1;
    logic              out_valid_2;
    logic [DATA_W-1:0] out_data_2;
    logic              out_stall_1;
    logic              out_stall_2;
    logic              global_stall;
    logic              timeout_err;

    modport master (
        input  req_1, data_1, flush_1,
        input  req_2, data_2, flush_2,
        input  res_done, res_result,
        output res_start, res_operand, res_id,
        output out_valid_1, out_data_1, out_valid_2, out_data_2,
        output out_stall_1, out_stall_2, global_stall, timeout_err
    );

    modport slave (
        output req_1, data_1, flush_1,
        output req_2, data_2, flush_2,
        output res_done, res_result,
        input  res_start, res_operand, res_id,
        input  out_valid_1, out_data_1, out_valid_2, out_data_2,
        input  out_stall_1, out_stall_2, global_stall, timeout_err
    );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Round-robin sequencer sharing one multi-cycle resource between two pipelines:
// issues one operand per grant, returns the result to its owner, drives stalls and timeout.
module shared_resource_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MAX_LAT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    shared_resource_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              last_grant;
    logic              elig_1;
    logic              elig_2;
    logic              gnt_vld;
    logic              gnt_id;
    logic              is_idle;
    logic              is_busy;
    logic              accept;
    logic              stall_1;
    logic              stall_2;
    logic              owner_flush;
    logic              done_hit;
    logic              timeout_hit;
    logic              deliver;

    logic              squash;
    logic [CNT_W-1:0]  cnt;

    logic              start_p1;
    logic              id_p1;
    logic [DATA_W-1:0] operand_p1;
    logic              vld_1_p2;
    logic              vld_2_p2;
    logic [DATA_W-1:0] data_1_p2;
    logic [DATA_W-1:0] data_2_p2;
    logic              timeout_q;

    // Grant selection and stall generation, all combinational on the current cycle
    always_comb begin
        elig_1  = bus.req_1 & ~bus.flush_1;
        elig_2  = bus.req_2 & ~bus.flush_2;
        gnt_vld = elig_1 | elig_2;
        if (elig_1 && elig_2) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = elig_2;
        end
        is_idle = (state == IDLE);
        is_busy = (state == BUSY);
        accept  = is_idle & gnt_vld;
        stall_1 = bus.req_1 & ~(accept & ~gnt_id);
        stall_2 = bus.req_2 & ~(accept & gnt_id);
    end

    // Completion: a result arriving on the MAX_LAT cycle beats the timeout
    always_comb begin
        owner_flush = id_p1 ? bus.flush_2 : bus.flush_1;
        done_hit    = is_busy & bus.res_done;
        timeout_hit = is_busy & ~bus.res_done & (cnt == CNT_W'(MAX_LAT));
        deliver     = done_hit & ~(squash | owner_flush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (done_hit || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue stage: operand/owner latched on accept, start pulse the following cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_p1   <= 1'b0;
            id_p1      <= 1'b0;
            operand_p1 <= '0;
            squash     <= 1'b0;
            cnt        <= '0;
        end else begin
            start_p1 <= accept;
            if (accept) begin
                id_p1      <= gnt_id;
                operand_p1 <= gnt_id ? bus.data_2 : bus.data_1;
                squash     <= 1'b0;
                cnt        <= CNT_W'(1);
            end else if (is_busy) begin
                cnt <= cnt + CNT_W'(1);
                if (owner_flush) begin
                    squash <= 1'b1;
                end
            end
        end
    end

    // Return stage: result routed to its owner, round-robin pointer updated on completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_1_p2   <= 1'b0;
            vld_2_p2   <= 1'b0;
            data_1_p2  <= '0;
            data_2_p2  <= '0;
            last_grant <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            vld_1_p2 <= deliver & ~id_p1;
            vld_2_p2 <= deliver & id_p1;
            if (deliver && !id_p1) begin
                data_1_p2 <= bus.res_result;
            end
            if (deliver && id_p1) begin
                data_2_p2 <= bus.res_result;
            end
            if (done_hit || timeout_hit) begin
                last_grant <= id_p1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.res_start    = start_p1;
    assign bus.res_operand  = operand_p1;
    assign bus.res_id       = id_p1;
    assign bus.out_valid_1  = vld_1_p2;
    assign bus.out_data_1   = data_1_p2;
    assign bus.out_valid_2  = vld_2_p2;
    assign bus.out_data_2   = data_2_p2;
    assign bus.out_stall_1  = stall_1;
    assign bus.out_stall_2  = stall_2;
    assign bus.global_stall = stall_1 | stall_2;
    assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed bench for shared_resource_arbiter: single op, alternation, flush, timeout,
// reset while busy and flushed request in IDLE.
module tb_shared_resource_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    shared_resource_arbiter_if #(.DATA_W(32)) bus ();

    shared_resource_arbiter #(.DATA_W(32), .MAX_LAT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_id;
        logic prev_id;

        bus.req_1 = 1'b0; bus.data_1 = '0; bus.flush_1 = 1'b0;
        bus.req_2 = 1'b0; bus.data_2 = '0; bus.flush_2 = 1'b0;
        bus.res_done = 1'b0; bus.res_result = '0;

        // Reset state
        tick(); tick();
        #2;
        chk1("rst_start", bus.res_start, 1'b0);
        chkw("rst_operand", bus.res_operand, 32'h0);
        chk1("rst_valid_1", bus.out_valid_1, 1'b0);
        chk1("rst_valid_2", bus.out_valid_2, 1'b0);
        chkw("rst_data_1", bus.out_data_1, 32'h0);
        chk1("rst_gstall", bus.global_stall, 1'b0);
        chk1("rst_timeout", bus.timeout_err, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Single request from pipe 1, result 0x22 after k=3
        bus.req_1 = 1'b1; bus.data_1 = 32'h11;
        #2;
        chk1("s1_stall_T", bus.out_stall_1, 1'b0);
        chk1("s1_gstall_T", bus.global_stall, 1'b0);
        tick();
        bus.req_1 = 1'b0;
        #2;
        chk1("s1_start_T1", bus.res_start, 1'b1);
        chkw("s1_operand", bus.res_operand, 32'h11);
        chk1("s1_id", bus.res_id, 1'b0);
        tick();
        #2;
        chk1("s1_start_T2", bus.res_start, 1'b0);
        tick();
        bus.res_done = 1'b1; bus.res_result = 32'h22;
        #2;
        chk1("s1_valid_T3", bus.out_valid_1, 1'b0);
        tick();
        bus.res_done = 1'b0;
        #2;
        chk1("s1_valid_T4", bus.out_valid_1, 1'b1);
        chkw("s1_data_T4", bus.out_data_1, 32'h22);
        chk1("s1_valid2_T4", bus.out_valid_2, 1'b0);
        tick();
        #2;
        chk1("s1_valid_T5", bus.out_valid_1, 1'b0);
        chkw("s1_hold_T5", bus.out_data_1, 32'h22);

        // Both pipes requesting; pipe 1 was served last so pipe 2 goes first
        tick();
        bus.req_1 = 1'b1; bus.data_1 = 32'hA1;
        bus.req_2 = 1'b1; bus.data_2 = 32'hB2;
        prev_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_id = ((i % 2) == 0);
            #2;
            chk1($sformatf("alt%0d_stall_1", i), bus.out_stall_1, exp_id);
            chk1($sformatf("alt%0d_stall_2", i), bus.out_stall_2, ~exp_id);
            chk1($sformatf("alt%0d_gstall", i), bus.global_stall, 1'b1);
            if (i > 0) begin
                chk1($sformatf("alt%0d_prev_v1", i), bus.out_valid_1, ~prev_id);
                chk1($sformatf("alt%0d_prev_v2", i), bus.out_valid_2, prev_id);
            end
            tick();
            #2;
            chk1($sformatf("alt%0d_start", i), bus.res_start, 1'b1);
            chk1($sformatf("alt%0d_id", i), bus.res_id, exp_id);
            chkw($sformatf("alt%0d_operand", i), bus.res_operand, exp_id ? 32'hB2 : 32'hA1);
            chk1($sformatf("alt%0d_busy_st1", i), bus.out_stall_1, 1'b1);
            chk1($sformatf("alt%0d_busy_st2", i), bus.out_stall_2, 1'b1);
            tick();
            bus.res_done = 1'b1; bus.res_result = 32'h100 + i;
            #2;
            chk1($sformatf("alt%0d_done_gstall", i), bus.global_stall, 1'b1);
            tick();
            bus.res_done = 1'b0;
            prev_id = exp_id;
        end
        bus.req_1 = 1'b0; bus.req_2 = 1'b0;
        #2;
        chk1("alt_last_v1", bus.out_valid_1, 1'b1);
        chkw("alt_last_d1", bus.out_data_1, 32'h103);
        chkw("alt_last_d2", bus.out_data_2, 32'h102);
        chk1("alt_idle_gstall", bus.global_stall, 1'b0);

        // Pipe 2 op squashed by flush_2; pipe 1 waits and is granted afterwards
        tick();
        bus.req_2 = 1'b1; bus.data_2 = 32'hC3;
        #2;
        chk1("fl_stall_2", bus.out_stall_2, 1'b0);
        tick();
        bus.req_2 = 1'b0;
        bus.req_1 = 1'b1; bus.data_1 = 32'hD4;
        #2;
        chk1("fl_id", bus.res_id, 1'b1);
        chk1("fl_stall_1_busy", bus.out_stall_1, 1'b1);
        tick();
        bus.flush_2 = 1'b1;
        tick();
        bus.flush_2 = 1'b0;
        bus.res_done = 1'b1; bus.res_result = 32'h55;
        tick();
        bus.res_done = 1'b0;
        #2;
        chk1("fl_no_valid_2", bus.out_valid_2, 1'b0);
        chkw("fl_data_2_kept", bus.out_data_2, 32'h102);
        chk1("fl_stall_1_idle", bus.out_stall_1, 1'b0);
        tick();
        bus.req_1 = 1'b0;
        #2;
        chk1("fl_p1_start", bus.res_start, 1'b1);
        chk1("fl_p1_id", bus.res_id, 1'b0);
        chkw("fl_p1_operand", bus.res_operand, 32'hD4);

        // No res_done: timeout after 8 BUSY cycles (currently BUSY cycle 1)
        for (int i = 2; i <= 8; i++) begin
            tick();
        end
        #2;
        chk1("to_before", bus.timeout_err, 1'b0);
        tick();
        bus.req_2 = 1'b1; bus.data_2 = 32'hE5;
        #2;
        chk1("to_err", bus.timeout_err, 1'b1);
        chk1("to_no_valid_1", bus.out_valid_1, 1'b0);
        chk1("to_idle_grant", bus.out_stall_2, 1'b0);
        tick();
        bus.req_2 = 1'b0;
        #2;
        chk1("to_new_start", bus.res_start, 1'b1);
        chk1("to_new_id", bus.res_id, 1'b1);
        chkw("to_new_operand", bus.res_operand, 32'hE5);
        chkw("to_data_1_kept", bus.out_data_1, 32'h103);
        chk1("to_sticky", bus.timeout_err, 1'b1);

        // Reset while BUSY, then a stray res_done
        tick();
        reset = 1'b1;
        #2;
        chk1("rb_start", bus.res_start, 1'b0);
        chkw("rb_operand", bus.res_operand, 32'h0);
        chk1("rb_id", bus.res_id, 1'b0);
        chkw("rb_data_1", bus.out_data_1, 32'h0);
        chkw("rb_data_2", bus.out_data_2, 32'h0);
        chk1("rb_timeout", bus.timeout_err, 1'b0);
        tick();
        reset = 1'b0;
        bus.res_done = 1'b1; bus.res_result = 32'h77;
        tick();
        bus.res_done = 1'b0;
        bus.req_1 = 1'b1; bus.data_1 = 32'h31;
        bus.req_2 = 1'b1; bus.data_2 = 32'h32;
        #2;
        chk1("rb_no_v1", bus.out_valid_1, 1'b0);
        chk1("rb_no_v2", bus.out_valid_2, 1'b0);
        chkw("rb_d2_zero", bus.out_data_2, 32'h0);
        chk1("rb_tie_st1", bus.out_stall_1, 1'b0);
        chk1("rb_tie_st2", bus.out_stall_2, 1'b1);
        tick();
        bus.req_1 = 1'b0; bus.req_2 = 1'b0;
        #2;
        chk1("rb_tie_id", bus.res_id, 1'b0);
        tick();
        bus.res_done = 1'b1; bus.res_result = 32'h99;
        tick();
        bus.res_done = 1'b0;
        #2;
        chk1("rb_v1", bus.out_valid_1, 1'b1);
        chkw("rb_d1", bus.out_data_1, 32'h99);

        // Flushed request in IDLE is never granted
        tick();
        bus.req_1 = 1'b1; bus.flush_1 = 1'b1;
        #2;
        chk1("fi_stall_1", bus.out_stall_1, 1'b1);
        tick();
        #2;
        chk1("fi_start_a", bus.res_start, 1'b0);
        tick();
        #2;
        chk1("fi_start_b", bus.res_start, 1'b0);
        bus.req_1 = 1'b0; bus.flush_1 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
